ifetch: RTL

Instruction fetch unit: the stage directly upstream of the decoder. Requests 32-bit instruction words from the memory controller, predecodes each returned word to choose the next fetch PC (JAL target, BHT-predicted branch, stop on JALR), and buffers `{inst, pc, pred_jump}` in a small FIFO whose head drives the decoder. Handles the decoder's JALR pause/release handshake and ROB rollback redirects.

---
 rtl/ifetch_pkg.sv | 43 ++++
 rtl/ifetch_if.sv | 25 ++
 rtl/ifetch_inst_queue.sv | 54 +++++
 rtl/ifetch.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch unit: opcodes, FSM states,
// queue entry layout, immediate extraction and BHT counter update.
package ifetch_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MEM  = 2'd1,
        DISCARD   = 2'd2,
        JALR_WAIT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } fetch_entry_t;

    function automatic logic [31:0] j_imm(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != 2'b11) nxt = cnt + 2'b01;
            else              nxt = cnt;
        end else begin
            if (cnt != 2'b00) nxt = cnt - 2'b01;
            else              nxt = cnt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: memory-controller request channel plus decoder side.
interface ifetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        dec_stall;
    logic        inst_rdy;
    logic [31:0] inst;
    logic [31:0] inst_PC;
    logic        pred_jump;
    logic        JALR_need_pause;
    logic        JALR_pause_rej;
    logic [31:0] JALR_PC;

    modport master (
        output mem_req, mem_addr, inst_rdy, inst, inst_PC, pred_jump,
        input  mem_ack, mem_data, dec_stall, JALR_need_pause, JALR_pause_rej, JALR_PC
    );

    modport slave (
        input  mem_req, mem_addr, inst_rdy, inst, inst_PC, pred_jump,
        output mem_ack, mem_data, dec_stall, JALR_need_pause, JALR_pause_rej, JALR_PC
    );
endinterface

// File: rtl/ifetch_inst_queue.sv
// Small synchronous FIFO of fetched entries; flush wins over push and pop.
module inst_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_entry,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_ok_s;

    assign pop_ok_s = pop && (count_r != {CNT_W{1'b0}});
    assign head     = mem_r[rd_ptr_r];
    assign count    = count_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= '0;
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory request, predecode-driven next PC,
// 2-bit BHT, JALR stall handshake and rollback redirect feeding an entry queue.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned BHT_INDEX_W = 6,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [31:0] rollback_pc,
    ifetch_if.master    bus,
    input  logic        br_update,
    input  logic [31:0] br_pc,
    input  logic        br_taken
);
    localparam int               CNT_W    = $clog2(QUEUE_DEPTH) + 1;
    localparam int               BHT_SIZE = 1 << BHT_INDEX_W;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);

    fetch_state_e           state_r, state_s;
    logic [31:0]            fetch_pc_r, fetch_pc_s;
    logic [31:0]            mem_addr_r, mem_addr_s;
    logic                   mem_req_r, mem_req_s;
    logic [1:0]             bht_r [BHT_SIZE];
    logic [BHT_INDEX_W-1:0] lookup_idx_s, update_idx_s;
    logic [31:0]            pred_pc_s;
    logic                   pred_s, is_jalr_s;
    logic                   push_s, flush_s, pop_s;
    logic [CNT_W-1:0]       count_s;
    fetch_entry_t           push_entry_s, head_s;
    logic                   unused_s;

    assign lookup_idx_s = mem_addr_r[BHT_INDEX_W+1:2];
    assign update_idx_s = br_pc[BHT_INDEX_W+1:2];
    assign push_entry_s = '{inst: bus.mem_data, pc: mem_addr_r, pred: pred_s};
    assign pop_s        = rdy && bus.inst_rdy && !bus.dec_stall;
    assign unused_s     = ^{bus.JALR_need_pause, br_pc[31:BHT_INDEX_W+2], br_pc[1:0]};

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.inst_rdy  = (count_s != {CNT_W{1'b0}});
    assign bus.inst      = head_s.inst;
    assign bus.inst_PC   = head_s.pc;
    assign bus.pred_jump = head_s.pred;

    // Predecode of the returning word: next fetch PC and jump prediction.
    always_comb begin
        pred_pc_s = mem_addr_r + 32'd4;
        pred_s    = 1'b0;
        is_jalr_s = 1'b0;
        case (bus.mem_data[6:0])
            OPC_JAL: begin
                pred_pc_s = mem_addr_r + j_imm(bus.mem_data);
                pred_s    = 1'b1;
            end
            OPC_BRANCH: begin
                if (bht_r[lookup_idx_s][1]) begin
                    pred_pc_s = mem_addr_r + b_imm(bus.mem_data);
                    pred_s    = 1'b1;
                end else begin
                    pred_pc_s = mem_addr_r + 32'd4;
                    pred_s    = 1'b0;
                end
            end
            OPC_JALR: is_jalr_s = 1'b1;
            default:  pred_pc_s = mem_addr_r + 32'd4;
        endcase
    end

    // Next-state logic; rollback overrides every state.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        mem_req_s  = mem_req_r;
        mem_addr_s = mem_addr_r;
        push_s     = 1'b0;
        flush_s    = 1'b0;
        if (rollback) begin
            flush_s    = 1'b1;
            fetch_pc_s = rollback_pc;
            // An un-acked request must still complete, so its data is dropped later.
            if ((state_r == WAIT_MEM || state_r == DISCARD) && !bus.mem_ack) begin
                state_s = DISCARD;
            end else begin
                state_s   = IDLE;
                mem_req_s = 1'b0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (count_s < DEPTH_C) begin
                        mem_req_s  = 1'b1;
                        mem_addr_s = fetch_pc_r;
                        state_s    = WAIT_MEM;
                    end else begin
                        state_s = IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_ack) begin
                        push_s     = 1'b1;
                        mem_req_s  = 1'b0;
                        fetch_pc_s = pred_pc_s;
                        state_s    = is_jalr_s ? JALR_WAIT : IDLE;
                    end else begin
                        state_s = WAIT_MEM;
                    end
                end
                DISCARD: begin
                    if (bus.mem_ack) begin
                        mem_req_s = 1'b0;
                        state_s   = IDLE;
                    end else begin
                        state_s = DISCARD;
                    end
                end
                JALR_WAIT: begin
                    if (bus.JALR_pause_rej) begin
                        fetch_pc_s = bus.JALR_PC;
                        state_s    = IDLE;
                    end else begin
                        state_s = JALR_WAIT;
                    end
                end
                default: begin
                    mem_req_s = 1'b0;
                    state_s   = IDLE;
                end
            endcase
        end
    end

    // Fetch FSM and request registers; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
        end else if (rdy) begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
        end
    end

    // BHT training; lookups in the same cycle see the old counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_SIZE; i++) bht_r[i] <= 2'b01;
        end else if (rdy && br_update) begin
            bht_r[update_idx_s] <= bht_next(bht_r[update_idx_s], br_taken);
        end
    end

    inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s && rdy),
        .pop        (pop_s),
        .flush      (flush_s && rdy),
        .push_entry (push_entry_s),
        .head       (head_s),
        .count      (count_s)
    );

endmodule
